// File: rtl/qam_mapper_if.sv
// Handshake bundle for qam_mapper: 4-bit words in, registered I/Q symbols out.
// The slave modport is the mapper's view; the master modport is the producer/consumer view.
interface qam_mapper_if;
   logic              enable;
   logic [3:0]        data_in;
   logic              data_valid;
   logic              data_ready;
   logic signed [7:0] I_out;
   logic signed [7:0] Q_out;
   logic              sym_valid;
   logic              busy;

   modport master (
      output enable, data_in, data_valid,
      input  data_ready, I_out, Q_out, sym_valid, busy
   );

   modport slave (
      input  enable, data_in, data_valid,
      output data_ready, I_out, Q_out, sym_valid, busy
   );
endinterface

// File: rtl/qam_mapper.sv
// 16-QAM Gray mapper behind a small input FIFO; one symbol per enabled cycle.
// Optional macro QAM_MAPPER_PREAMBLE_EN inserts a 4-symbol preamble at each burst start.
module qam_mapper #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int          LEVEL      = 32
) (
   input logic         symbol_clock,
   input logic         rst,
   qam_mapper_if.slave bus
);
   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   localparam logic signed [7:0] LvlP1 = 8'(LEVEL);
   localparam logic signed [7:0] LvlP3 = 8'(3 * LEVEL);
   localparam logic signed [7:0] LvlN1 = -LvlP1;
   localparam logic signed [7:0] LvlN3 = -LvlP3;

`ifdef QAM_MAPPER_PREAMBLE_EN
   typedef enum logic [1:0] {StIdle, StPreamble, StData} state_e;
`else
   typedef enum logic [0:0] {StIdle, StData} state_e;
`endif

   function automatic logic signed [7:0] gray_map(input logic [1:0] bits);
      case (bits)
         2'b00:   return LvlN3;
         2'b01:   return LvlN1;
         2'b11:   return LvlP1;
         default: return LvlP3;
      endcase
   endfunction

   logic [3:0]        mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   state_e            state_q, state_d;
   logic signed [7:0] i_q, i_d;
   logic signed [7:0] q_q, q_d;
   logic              valid_q, valid_d;
   logic              push, pop;
   logic [3:0]        head;
`ifdef QAM_MAPPER_PREAMBLE_EN
   logic [1:0]        pre_cnt_q, pre_cnt_d;
`endif

   assign bus.data_ready = (count_q < CntW'(FIFO_DEPTH));
   assign bus.I_out      = i_q;
   assign bus.Q_out      = q_q;
   assign bus.sym_valid  = valid_q;
   assign bus.busy       = (state_q != StIdle);
   assign head           = mem_q[rd_ptr_q];

   always_comb begin
      push    = bus.data_valid && bus.data_ready;
      pop     = 1'b0;
      state_d = state_q;
      i_d     = '0;
      q_d     = '0;
      valid_d = 1'b0;
`ifdef QAM_MAPPER_PREAMBLE_EN
      pre_cnt_d = pre_cnt_q;
`endif
      // Enable low holds everything and forces a zero, non-valid output.
      if (bus.enable) begin
         case (state_q)
            StIdle: begin
               if (count_q != '0) begin
`ifdef QAM_MAPPER_PREAMBLE_EN
                  state_d   = StPreamble;
                  i_d       = LvlP3;
                  q_d       = LvlP3;
                  valid_d   = 1'b1;
                  pre_cnt_d = 2'd1;
`else
                  state_d = StData;
                  pop     = 1'b1;
`endif
               end
            end
`ifdef QAM_MAPPER_PREAMBLE_EN
            StPreamble: begin
               valid_d   = 1'b1;
               i_d       = pre_cnt_q[0] ? LvlN3 : LvlP3;
               q_d       = pre_cnt_q[0] ? LvlN3 : LvlP3;
               pre_cnt_d = pre_cnt_q + 2'd1;
               if (pre_cnt_q == 2'd3) state_d = StData;
            end
`endif
            StData: begin
               if (count_q != '0) pop = 1'b1;
               else state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      if (pop) begin
         i_d     = gray_map(head[3:2]);
         q_d     = gray_map(head[1:0]);
         valid_d = 1'b1;
      end

      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q + CntW'(push) - CntW'(pop);
   end

   always_ff @(posedge symbol_clock) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= StIdle;
         i_q      <= '0;
         q_q      <= '0;
         valid_q  <= 1'b0;
`ifdef QAM_MAPPER_PREAMBLE_EN
         pre_cnt_q <= '0;
`endif
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         i_q      <= i_d;
         q_q      <= q_d;
         valid_q  <= valid_d;
`ifdef QAM_MAPPER_PREAMBLE_EN
         pre_cnt_q <= pre_cnt_d;
`endif
      end
   end

   // Storage needs no reset; pointers and count define what is live.
   always_ff @(posedge symbol_clock) begin
      if (push && !rst) mem_q[wr_ptr_q] <= bus.data_in;
   end
endmodule

// File: tb/tb_qam_mapper.sv
// Scoreboard bench for qam_mapper: stimulus queues expected I/Q pairs, a negedge monitor
// pops and compares whenever sym_valid is high and checks zeroed outputs otherwise.
module tb_qam_mapper;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   exp_i[$];
   int   exp_q[$];

   qam_mapper_if bus();

   qam_mapper #(
      .FIFO_DEPTH(4),
      .LEVEL     (32)
   ) dut (
      .symbol_clock(clk),
      .rst         (rst),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int lvl(input logic [1:0] b);
      case (b)
         2'b00:   return -96;
         2'b01:   return -32;
         2'b11:   return 32;
         default: return 96;
      endcase
   endfunction

   // Monitor: decoupled from stimulus, runs away from the active edge.
   always @(negedge clk) begin
      int ei;
      int eq;
      if (!rst) begin
         if (bus.sym_valid === 1'b1) begin
            if (exp_i.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_symbol: got (%0d,%0d), required no symbol",
                        $signed(bus.I_out), $signed(bus.Q_out));
            end else begin
               ei = exp_i.pop_front();
               eq = exp_q.pop_front();
               check("sym_i", $signed(bus.I_out), ei);
               check("sym_q", $signed(bus.Q_out), eq);
            end
         end else begin
            check("idle_i", $signed(bus.I_out), 0);
            check("idle_q", $signed(bus.Q_out), 0);
         end
      end
   end

   task automatic expect_sym(input int ei, input int eq);
      exp_i.push_back(ei);
      exp_q.push_back(eq);
   endtask

   // Present one word for one edge; it is expected only if the FIFO accepts it.
   task automatic send_exp(input logic [3:0] w, input int ei, input int eq);
      bus.data_valid = 1'b1;
      bus.data_in    = w;
      if (bus.data_ready === 1'b1) expect_sym(ei, eq);
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      exp_i.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [3:0] w;
      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      bus.enable     = 1'b1;
      bus.data_in    = 4'h0;
      bus.data_valid = 1'b0;

      do_reset();
      check("rst_sym_valid", bus.sym_valid, 0);
      check("rst_i", $signed(bus.I_out), 0);
      check("rst_q", $signed(bus.Q_out), 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.data_ready, 1);

`ifdef QAM_MAPPER_PREAMBLE_EN
      expect_sym(96, 96);
      expect_sym(-96, -96);
      expect_sym(96, 96);
      expect_sym(-96, -96);
      send_exp(4'h3, -96, 32);
      tick(8);
      check("pre_drain", exp_i.size(), 0);
      check("pre_busy", bus.busy, 0);
`else
      // Four back-to-back words into an idle, enabled mapper.
      send_exp(4'h0, -96, -96);
      send_exp(4'h5, -32, -32);
      send_exp(4'hF, 32, 32);
      send_exp(4'hA, 96, 96);
      tick(4);
      check("seq_sym_valid", bus.sym_valid, 0);
      check("seq_busy", bus.busy, 0);
      check("seq_drain", exp_i.size(), 0);

      // Fill while stalled; the fifth word must be refused.
      do_reset();
      bus.enable = 1'b0;
      send_exp(4'h1, -96, -32);
      send_exp(4'h2, -96, 96);
      send_exp(4'h3, -96, 32);
      send_exp(4'h4, -32, -96);
      check("full_ready", bus.data_ready, 0);
      check("full_busy", bus.busy, 0);
      send_exp(4'h5, -32, -32);
      bus.enable = 1'b1;
      tick(8);
      check("full_drain", exp_i.size(), 0);
      check("full_ready_after", bus.data_ready, 1);

      // Continuous random stream: no bubbles.
      do_reset();
      bus.enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         w = 4'($urandom_range(0, 15));
         send_exp(w, lvl(w[3:2]), lvl(w[1:0]));
         if (i > 0) check("stream_valid", bus.sym_valid, 1);
      end
      tick(1);
      check("stream_last_valid", bus.sym_valid, 1);
      tick(3);
      check("stream_drain", exp_i.size(), 0);
      check("stream_busy", bus.busy, 0);

      // Enable dropped for two cycles mid-burst.
      do_reset();
      bus.enable = 1'b0;
      send_exp(4'h6, -32, 96);
      send_exp(4'h9, 96, -32);
      send_exp(4'hC, 32, -96);
      send_exp(4'hE, 32, 96);
      bus.enable = 1'b1;
      tick(2);
      bus.enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick(1);
         check("stall_valid", bus.sym_valid, 0);
         check("stall_i", $signed(bus.I_out), 0);
         check("stall_q", $signed(bus.Q_out), 0);
         check("stall_busy", bus.busy, 1);
      end
      bus.enable = 1'b1;
      tick(6);
      check("stall_drain", exp_i.size(), 0);

      // Reset mid-burst with three words still queued.
      do_reset();
      bus.enable = 1'b0;
      send_exp(4'h1, -96, -32);
      send_exp(4'h2, -96, 96);
      send_exp(4'h3, -96, 32);
      send_exp(4'h4, -32, -96);
      bus.enable = 1'b1;
      tick(1);
      check("burst_busy", bus.busy, 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      exp_i.delete();
      exp_q.delete();
      check("mrst_valid", bus.sym_valid, 0);
      check("mrst_i", $signed(bus.I_out), 0);
      check("mrst_q", $signed(bus.Q_out), 0);
      check("mrst_busy", bus.busy, 0);
      check("mrst_ready", bus.data_ready, 1);
      tick(3);
      send_exp(4'h9, 96, -32);
      tick(4);
      check("mrst_drain", exp_i.size(), 0);
      check("mrst_idle", bus.busy, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
